// File: rtl/spi_slave.sv
// SPI mode-0 responder: inputs synchronised into clk, full-duplex word shifting,
// one-entry transmit holding register with valid/ready write handshake.
module spi_slave #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sck,
   input  logic                  ss_n,
   input  logic                  mosi,
   output logic                  miso,
   output logic                  miso_oe,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  busy,
   output logic                  tx_underrun
);

   localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t state, state_next;

   logic [SYNC_STAGES-1:0] sck_pipe, ss_pipe, mosi_pipe;
   logic                   sck_d, ss_d;
   logic                   sck_s, ss_s, mosi_s;
   logic                   sck_rise, sck_fall, ss_rise, ss_fall;

   logic [CNT_W-1:0]      bit_cnt, bit_cnt_next;
   logic [DATA_WIDTH-1:0] tx_shift, tx_shift_next;
   logic [DATA_WIDTH-1:0] rx_shift, rx_shift_next;
   logic [DATA_WIDTH-1:0] rx_data_next;
   logic [DATA_WIDTH-1:0] hold_data, hold_data_next;
   logic                  hold_full, hold_full_next;
   logic                  rx_valid_next, underrun_next;
   logic                  load;

   // ss_n synchroniser resets to deselected so reset never looks like a frame start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_pipe  <= '0;
         ss_pipe   <= '1;
         mosi_pipe <= '0;
         sck_d     <= 1'b0;
         ss_d      <= 1'b1;
      end else begin
         sck_pipe  <= {sck_pipe[SYNC_STAGES-2:0], sck};
         ss_pipe   <= {ss_pipe[SYNC_STAGES-2:0], ss_n};
         mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], mosi};
         sck_d     <= sck_pipe[SYNC_STAGES-1];
         ss_d      <= ss_pipe[SYNC_STAGES-1];
      end
   end

   assign sck_s    = sck_pipe[SYNC_STAGES-1];
   assign ss_s     = ss_pipe[SYNC_STAGES-1];
   assign mosi_s   = mosi_pipe[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_d;
   assign sck_fall = ~sck_s & sck_d;
   assign ss_rise  = ss_s & ~ss_d;
   assign ss_fall  = ~ss_s & ss_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         tx_shift    <= '0;
         rx_shift    <= '0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;
         hold_data   <= '0;
         hold_full   <= 1'b0;
      end else begin
         state       <= state_next;
         bit_cnt     <= bit_cnt_next;
         tx_shift    <= tx_shift_next;
         rx_shift    <= rx_shift_next;
         rx_data     <= rx_data_next;
         rx_valid    <= rx_valid_next;
         tx_underrun <= underrun_next;
         hold_data   <= hold_data_next;
         hold_full   <= hold_full_next;
      end
   end

   always_comb begin
      state_next     = state;
      bit_cnt_next   = bit_cnt;
      tx_shift_next  = tx_shift;
      rx_shift_next  = rx_shift;
      rx_data_next   = rx_data;
      rx_valid_next  = 1'b0;
      underrun_next  = 1'b0;
      hold_data_next = hold_data;
      hold_full_next = hold_full;
      load           = 1'b0;

      case (state)
         IDLE: begin
            if (ss_fall) begin
               state_next   = SHIFT;
               bit_cnt_next = '0;
               load         = 1'b1;
            end
         end
         SHIFT: begin
            if (ss_rise) begin
               state_next    = IDLE;
               bit_cnt_next  = '0;
               tx_shift_next = '0;
               rx_shift_next = '0;
            end else if (sck_rise) begin
               rx_shift_next = {rx_shift[DATA_WIDTH-2:0], mosi_s};
               if (bit_cnt == LAST_BIT) begin
                  bit_cnt_next  = '0;
                  rx_data_next  = {rx_shift[DATA_WIDTH-2:0], mosi_s};
                  rx_valid_next = 1'b1;
               end else begin
                  bit_cnt_next = bit_cnt + CNT_W'(1);
               end
            end else if (sck_fall) begin
               if (bit_cnt != '0) begin
                  tx_shift_next = {tx_shift[DATA_WIDTH-2:0], 1'b0};
               end else begin
                  load = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      // Load sees the pre-write holding state; a same-cycle write lands for the next word.
      if (load) begin
         if (hold_full) begin
            tx_shift_next  = hold_data;
            hold_full_next = 1'b0;
         end else begin
            tx_shift_next = '0;
            underrun_next = 1'b1;
         end
      end

      if (tx_valid && !hold_full) begin
         hold_data_next = tx_data;
         hold_full_next = 1'b1;
      end
   end

   assign tx_ready = ~hold_full;
   assign busy     = (state == SHIFT);
   assign miso_oe  = (state == SHIFT);
   assign miso     = (state == SHIFT) ? tx_shift[DATA_WIDTH-1] : 1'b0;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: mode-0 master model, rx scoreboard queue, table of single-word frames
// plus hand-written back-to-back, underrun, abort, same-cycle load/write and reset sequences.
module tb_spi_slave;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sck = 1'b0;
   logic       ss_n = 1'b1;
   logic       mosi = 1'b0;
   logic       miso, miso_oe;
   logic [7:0] tx_data = '0;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid, busy, tx_underrun;

   spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .sck(sck), .ss_n(ss_n), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
      .tx_underrun(tx_underrun)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;
   int rx_pulses = 0;
   int un_cnt = 0;
   int un_at_start = 0;
   logic [7:0] rx_q[$];

   logic [7:0] f_mosi[4];
   logic [7:0] f_miso_exp[4];
   int         f_n = 1;
   int         f_hook = -1;
   logic [7:0] f_hook_data = '0;

   typedef struct {
      logic [7:0] tx;
      logic [7:0] mosi;
   } vec_t;
   vec_t vecs[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (!rst && tx_underrun) un_cnt++;
      if (!rst && rx_valid) begin
         rx_pulses++;
         if (rx_q.size() == 0) check("rx_unexpected", 32'(rx_data), 32'h1ff);
         else check("rx_data", 32'(rx_data), 32'(rx_q.pop_front()));
      end
   end

   task automatic write_tx(input logic [7:0] d);
      int n = 0;
      @(negedge clk);
      tx_data  = d;
      tx_valid = 1'b1;
      while (!tx_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("tx_ready_wait", 32'(tx_ready), 32'd1);
      @(posedge clk);
      #1 tx_valid = 1'b0;
      check("tx_ready_after_write", 32'(tx_ready), 32'd0);
   endtask

   // Master ends each frame by raising ss_n while sck is high, so no trailing word-boundary load.
   task automatic frame();
      logic [7:0] got;
      int un0;
      un0 = un_cnt;
      @(negedge clk);
      ss_n = 1'b0;
      wait_clk(6);
      un_at_start = un_cnt - un0;
      for (int w = 0; w < f_n; w++) begin
         rx_q.push_back(f_mosi[w]);
         got = '0;
         for (int i = 7; i >= 0; i--) begin
            mosi = f_mosi[w][i];
            wait_clk(5);
            sck = 1'b1;
            got[i] = miso;
            wait_clk(5);
            if (w == f_n - 1 && i == 0) begin
               ss_n = 1'b1;
               wait_clk(2);
               sck = 1'b0;
            end else begin
               sck = 1'b0;
               if (i == 0 && w == f_hook) begin
                  wait_clk(2);
                  tx_data  = f_hook_data;
                  tx_valid = 1'b1;
                  wait_clk(1);
                  tx_valid = 1'b0;
                  check("simul_ready_low", 32'(tx_ready), 32'd0);
               end
            end
         end
         check($sformatf("miso_word%0d", w), 32'(got), 32'(f_miso_exp[w]));
      end
      wait_clk(8);
   endtask

   task automatic drain();
      int n = 0;
      while (rx_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("rx_drain", 32'(rx_q.size()), 32'd0);
   endtask

   initial begin
      int rx0, un0;
      vecs[0] = '{tx: 8'hA5, mosi: 8'hB9};
      vecs[1] = '{tx: 8'h00, mosi: 8'hFF};
      vecs[2] = '{tx: 8'h81, mosi: 8'h7E};
      vecs[3] = '{tx: 8'h5A, mosi: 8'hC3};

      wait_clk(5);
      rst = 1'b0;
      wait_clk(2);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_tx_ready", 32'(tx_ready), 32'd1);
      check("rst_rx_data", 32'(rx_data), 32'd0);
      check("rst_miso_oe", 32'(miso_oe), 32'd0);

      foreach (vecs[k]) begin
         write_tx(vecs[k].tx);
         f_n = 1; f_hook = -1;
         f_mosi[0] = vecs[k].mosi;
         f_miso_exp[0] = vecs[k].tx;
         rx0 = rx_pulses; un0 = un_cnt;
         frame();
         drain();
         check("single_rx_pulses", 32'(rx_pulses - rx0), 32'd1);
         check("single_underrun", 32'(un_cnt - un0), 32'd0);
         check("single_busy_end", 32'(busy), 32'd0);
      end

      write_tx(8'h3C);
      f_n = 2; f_hook = -1;
      f_mosi[0] = 8'h12; f_mosi[1] = 8'h34;
      f_miso_exp[0] = 8'h3C; f_miso_exp[1] = 8'h81;
      rx0 = rx_pulses; un0 = un_cnt;
      fork
         frame();
         begin
            wait_clk(30);
            write_tx(8'h81);
         end
      join
      drain();
      check("b2b_rx_pulses", 32'(rx_pulses - rx0), 32'd2);
      check("b2b_underrun", 32'(un_cnt - un0), 32'd0);

      check("under_ready", 32'(tx_ready), 32'd1);
      f_n = 1; f_hook = -1;
      f_mosi[0] = 8'hFF; f_miso_exp[0] = 8'h00;
      rx0 = rx_pulses; un0 = un_cnt;
      frame();
      drain();
      check("under_at_start", 32'(un_at_start), 32'd1);
      check("under_total", 32'(un_cnt - un0), 32'd1);
      check("under_rx_data", 32'(rx_data), 32'hFF);

      rx0 = rx_pulses;
      @(negedge clk);
      ss_n = 1'b0; mosi = 1'b1;
      wait_clk(6);
      for (int e = 0; e < 5; e++) begin
         wait_clk(5);
         sck = ~sck;
      end
      wait_clk(5);
      ss_n = 1'b1;
      wait_clk(2);
      sck = 1'b0;
      wait_clk(10);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_miso_oe", 32'(miso_oe), 32'd0);
      check("abort_no_rx", 32'(rx_pulses - rx0), 32'd0);
      write_tx(8'h66);
      f_n = 1; f_mosi[0] = 8'h5A; f_miso_exp[0] = 8'h66;
      frame();
      drain();
      check("abort_next_pulses", 32'(rx_pulses - rx0), 32'd1);
      check("abort_next_rx", 32'(rx_data), 32'h5A);

      f_n = 3; f_hook = 0; f_hook_data = 8'hC7;
      f_mosi[0] = 8'h11; f_mosi[1] = 8'h22; f_mosi[2] = 8'h33;
      f_miso_exp[0] = 8'h00; f_miso_exp[1] = 8'h00; f_miso_exp[2] = 8'hC7;
      rx0 = rx_pulses; un0 = un_cnt;
      frame();
      drain();
      f_hook = -1;
      check("simul_underrun", 32'(un_cnt - un0), 32'd2);
      check("simul_rx_pulses", 32'(rx_pulses - rx0), 32'd3);

      @(negedge clk);
      ss_n = 1'b0;
      wait_clk(8);
      write_tx(8'h42);
      for (int e = 0; e < 3; e++) begin
         wait_clk(5);
         sck = ~sck;
      end
      check("pre_reset_busy", 32'(busy), 32'd1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_busy", 32'(busy), 32'd0);
      check("async_miso_oe", 32'(miso_oe), 32'd0);
      check("async_miso", 32'(miso), 32'd0);
      check("async_rx_data", 32'(rx_data), 32'd0);
      check("async_rx_valid", 32'(rx_valid), 32'd0);
      check("async_underrun", 32'(tx_underrun), 32'd0);
      check("async_tx_ready", 32'(tx_ready), 32'd1);
      ss_n = 1'b1; sck = 1'b0;
      wait_clk(4);
      rst = 1'b0;
      wait_clk(6);
      check("post_reset_busy", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
